ov7670_capture_ctrl: RTL and testbench
======================================

Name: ov7670_capture_ctrl

Overview:
Parametrised successor to the fixed 320x240 OV7670 frame writer. Pairs camera bytes into pixels and writes them to the frame buffer. Adds frame-synchronous start, single-shot or continuous capture, optional 2:1 decimation for VGA sources, frame completion status, and line/frame length error detection. Sits between the OV7670 pixel bus (PCLK domain, clk) and the frame buffer write port.

Parameters:
H_RES, 320, stored pixels per line
V_RES, 240, stored lines per frame
ADDR_W, 17, write address width; must satisfy 2^ADDR_W >= H_RES*V_RES
CNT_W, 11, width of internal pixel and line counters; must hold 2*max(H_RES,V_RES)

Ports:
clk  in  1  camera pixel clock
reset_n  in  1  asynchronous active-low reset
cap_en  in  1  capture enable
single  in  1  1 = capture one frame then stop; 0 = continuous
decim  in  1  1 = source is 2*H_RES x 2*V_RES; keep even pixels of even lines
err_clr  in  1  clears sticky error flags
href  in  1  camera line valid
vsync  in  1  camera vsync, high during vertical blanking
cam_data  in  8  camera byte
we  out  1  frame buffer write strobe
wAddr  out  ADDR_W  write address
wData  out  16  RGB565 pixel, first byte in [15:8]
busy  out  1  high in ARM or CAPTURE
frame_done  out  1  one-cycle pulse at end of each captured frame
frame_cnt  out  8  captured frames, wraps 255->0
err_line  out  1  sticky: a captured line had the wrong pixel count
err_frame  out  1  sticky: a captured frame had the wrong line count

Behaviour:
- Reset: state IDLE. All outputs 0. All counters 0.
- Edges are detected from the registered copies href_d and vsync_d: vs_rise, vs_fall, href_fall.
- FSM states: IDLE, SYNC, ARM, CAPTURE.
  - IDLE -> SYNC when cap_en=1.
  - SYNC -> ARM when vsync=1. This prevents capturing a partial frame.
  - ARM -> CAPTURE on vs_fall. decim and single are latched here. Address, line and pixel counters clear.
  - CAPTURE -> on vs_rise, pulse frame_done and increment frame_cnt. Then go to IDLE if single=1 or cap_en=0; otherwise go to ARM.
  - cap_en=0 in SYNC or ARM returns the FSM to IDLE on the next cycle. cap_en=0 in CAPTURE lets the current frame finish.
- Byte pairing, only while href=1 in CAPTURE:
  - The byte phase toggles every cycle and resets to 0 when href=0.
  - Phase 0 loads wData[15:8]. Phase 1 loads wData[7:0] and completes a source pixel.
- Source pixel index sp increments per completed pixel and clears on href_fall. Source line index sl increments on href_fall.
- Keep rule:
  - decim=0: keep every pixel.
  - decim=1: keep a pixel only when sp[0]=0 and sl[0]=0.
- Write rule:
  - A kept pixel writes only when stored pixel index < H_RES and stored line index < V_RES.
  - Excess pixels and lines are dropped with no write and no address change.
- Write timing:
  - we is high for exactly 1 cycle, in the cycle after the phase-1 byte is sampled. wAddr and wData are valid in that cycle.
  - A write takes at most one cycle in every two.
- Address generation:
  - No multiplier. A line_base accumulator adds H_RES at each stored line end.
  - wAddr = line_base + stored pixel index.
  - A short line therefore does not skew subsequent lines.
- err_line sets on href_fall of a stored line whose kept pixel count != H_RES.
- err_frame sets on vs_rise when the stored line count != V_RES.
- Errors hold until err_clr=1. If err_clr and a set event occur in the same cycle, set wins.
- href=1 outside CAPTURE is ignored. If vsync rises mid-line, the frame still ends and err_frame rules apply.
- Reset asserted mid-frame aborts with no frame_done. The next capture resynchronises via SYNC.

Decomposition:
- Package cam_pkg holds:
  - state enum cap_state_t (IDLE, SYNC, ARM, CAPTURE)
  - constants DEF_H_RES=320 and DEF_V_RES=240
  - function clog2-based width helpers
- One sub-module, ov7670_pix_assembler: byte phase, wData assembly, sp/sl counters and the keep decision. It outputs pix_valid and the indices. ov7670_capture_ctrl keeps the FSM, address generation, status and error logic.

Test Plan:
- Continuous mode, decim=0, two 320x240 frames: 76800 writes per frame with addresses 0..76799 in order. frame_done pulses twice, frame_cnt=2, no errors.
- cap_en raised mid-frame (vsync=0): no writes until the next vsync high then fall. The first write is at wAddr=0.
- decim=1, 640x480 source with pixel value = {sl[7:0], sp[7:0]}: 76800 writes, and wData at wAddr=321 equals {8'd2, 8'd2}.
- Line 5 carries 300 pixels: err_line=1. The first pixel of line 6 is written at wAddr=1920. err_clr clears the flag.
- single=1 with a 239-line frame: err_frame=1, frame_done pulses once, the FSM returns to IDLE, and no writes occur during the next frame.
- reset_n pulsed low at pixel 100 of line 50: all outputs 0 immediately. After release with cap_en=1, writes restart at wAddr=0 on the next full frame.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and sizing helpers for the OV7670 capture path.
// Holds the capture FSM encoding and default frame geometry.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    ARM,
    CAPTURE
  } cap_state_t;

  localparam int DEF_H_RES = 320;
  localparam int DEF_V_RES = 240;

  function automatic int addr_w(input int h, input int v);
    return $clog2(h * v);
  endfunction

  // Counters must reach 2*max(h,v) for a decimated source,
  // plus one bit so saturation never aliases a legal count.
  function automatic int cnt_w(input int h, input int v);
    return $clog2(2 * ((h > v) ? h : v)) + 1;
  endfunction

endpackage

// File: rtl/ov7670_pix_assembler.sv
// Pairs camera bytes into RGB565 pixels, tracks source pixel/line
// indices and decides which pixels survive 2:1 decimation.
// Ports: clk, reset_n, active (FSM in CAPTURE), clr (frame start),
//   decim, href, href_fall, cam_data in; pix_valid, pix_data,
//   px_idx/ln_idx (stored indices), line_end, line_px, lines_done out.
module ov7670_pix_assembler #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             active,
  input  logic             clr,
  input  logic             decim,
  input  logic             href,
  input  logic             href_fall,
  input  logic [7:0]       cam_data,
  output logic             pix_valid,
  output logic [15:0]      pix_data,
  output logic [CNT_W-1:0] px_idx,
  output logic [CNT_W-1:0] ln_idx,
  output logic             line_end,
  output logic [CNT_W-1:0] line_px,
  output logic [CNT_W-1:0] lines_done
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             phase_q, phase_d;
  logic [7:0]       hi_q, hi_d;
  logic [CNT_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] sl_q, sl_d;
  logic [CNT_W:0]   sp_inc;
  logic [CNT_W:0]   sl_inc;
  logic             keep_px;
  logic             keep_ln;

  always_comb begin
    phase_d = 1'b0;
    hi_d    = hi_q;
    sp_d    = sp_q;
    sl_d    = sl_q;
    if (clr) begin
      sp_d = '0;
      sl_d = '0;
    end else if (active) begin
      if (href) begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          hi_d = cam_data;
        end else if (sp_q != CMAX) begin
          sp_d = sp_q + 1'b1;
        end
      end
      // Counters saturate so an over-long line or frame
      // cannot wrap back into the stored window.
      if (href_fall) begin
        sp_d = '0;
        if (sl_q != CMAX) begin
          sl_d = sl_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
      sp_q    <= '0;
      sl_q    <= '0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
      sp_q    <= sp_d;
      sl_q    <= sl_d;
    end
  end

  assign keep_px = !decim || (!sp_q[0] && !sl_q[0]);
  assign keep_ln = !decim || !sl_q[0];

  assign pix_valid = active && href && phase_q && keep_px;
  assign pix_data  = {hi_q, cam_data};

  assign px_idx = decim ? (sp_q >> 1) : sp_q;
  assign ln_idx = decim ? (sl_q >> 1) : sl_q;

  // Kept counts round up: source pixels 0,2,4.. survive decimation.
  assign sp_inc = {1'b0, sp_q} + 1'b1;
  assign sl_inc = {1'b0, sl_q} + 1'b1;

  assign line_end   = active && href_fall && keep_ln;
  assign line_px    = decim ? sp_inc[CNT_W:1] : sp_q;
  assign lines_done = decim ? sl_inc[CNT_W:1] : sl_q;

endmodule

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 frame capture: frame-synchronous start, single/continuous
// modes, optional 2:1 decimation, frame status and length errors.
// Ports: clk/reset_n, cap_en, single, decim, err_clr, href, vsync,
//   cam_data in; we, wAddr, wData, busy, frame_done, frame_cnt,
//   err_line, err_frame out.
module ov7670_capture_ctrl
  import cam_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int ADDR_W = addr_w(H_RES, V_RES),
  parameter int CNT_W  = cnt_w(H_RES, V_RES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cap_en,
  input  logic              single,
  input  logic              decim,
  input  logic              err_clr,
  input  logic              href,
  input  logic              vsync,
  input  logic [7:0]        cam_data,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              err_line,
  output logic              err_frame
);

  cap_state_t state_q, state_d;

  logic              href_q;
  logic              vsync_q;
  logic              decim_q, decim_d;
  logic              single_q, single_d;
  logic              hold_q, hold_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic              eline_q, eline_d;
  logic              eframe_q, eframe_d;

  logic              vs_rise;
  logic              vs_fall;
  logic              href_fall;
  logic              start;
  logic              in_win;

  logic              pix_valid;
  logic [15:0]       pix_data;
  logic [CNT_W-1:0]  px_idx;
  logic [CNT_W-1:0]  ln_idx;
  logic              line_end;
  logic [CNT_W-1:0]  line_px;
  logic [CNT_W-1:0]  lines_done;

  assign vs_rise   = vsync && !vsync_q;
  assign vs_fall   = !vsync && vsync_q;
  assign href_fall = !href && href_q;
  assign start     = (state_q == ARM) && cap_en && vs_fall;

  ov7670_pix_assembler #(
    .CNT_W(CNT_W)
  ) u_asm (
    .clk       (clk),
    .reset_n   (reset_n),
    .active    (state_q == CAPTURE),
    .clr       (start),
    .decim     (decim_q),
    .href      (href),
    .href_fall (href_fall),
    .cam_data  (cam_data),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .px_idx    (px_idx),
    .ln_idx    (ln_idx),
    .line_end  (line_end),
    .line_px   (line_px),
    .lines_done(lines_done)
  );

  assign in_win = (px_idx < CNT_W'(H_RES))
               && (ln_idx < CNT_W'(V_RES));

  always_comb begin
    state_d     = state_q;
    decim_d     = decim_q;
    single_d    = single_q;
    line_base_d = line_base_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    fcnt_d      = fcnt_q;
    // A finished single shot stays parked until cap_en drops.
    hold_d      = hold_q && cap_en;
    eline_d     = eline_q && !err_clr;
    eframe_d    = eframe_q && !err_clr;

    unique case (state_q)
      IDLE: begin
        if (cap_en && !hold_q) state_d = SYNC;
      end
      SYNC: begin
        if (!cap_en)    state_d = IDLE;
        else if (vsync) state_d = ARM;
      end
      ARM: begin
        if (!cap_en) begin
          state_d = IDLE;
        end else if (vs_fall) begin
          state_d     = CAPTURE;
          decim_d     = decim;
          single_d    = single;
          line_base_d = '0;
        end
      end
      CAPTURE: begin
        if (vs_rise) begin
          done_d = 1'b1;
          fcnt_d = fcnt_q + 8'd1;
          if (lines_done != CNT_W'(V_RES)) eframe_d = 1'b1;
          if (single_q || !cap_en) begin
            state_d = IDLE;
            hold_d  = single_q && cap_en;
          end else begin
            state_d = ARM;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pix_valid && in_win) begin
      we_d    = 1'b1;
      waddr_d = line_base_q + ADDR_W'(px_idx);
      wdata_d = pix_data;
    end

    // Stored lines always advance by a full H_RES, so a short
    // line never shifts the lines after it.
    if (line_end && (ln_idx < CNT_W'(V_RES))) begin
      line_base_d = line_base_q + ADDR_W'(H_RES);
      if (line_px != CNT_W'(H_RES)) eline_d = 1'b1;
    end

    busy_d = (state_d == ARM) || (state_d == CAPTURE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      href_q      <= 1'b0;
      vsync_q     <= 1'b0;
      decim_q     <= 1'b0;
      single_q    <= 1'b0;
      hold_q      <= 1'b0;
      line_base_q <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fcnt_q      <= '0;
      eline_q     <= 1'b0;
      eframe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      href_q      <= href;
      vsync_q     <= vsync;
      decim_q     <= decim_d;
      single_q    <= single_d;
      hold_q      <= hold_d;
      line_base_q <= line_base_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fcnt_q      <= fcnt_d;
      eline_q     <= eline_d;
      eframe_q    <= eframe_d;
    end
  end

  assign we         = we_q;
  assign wAddr      = waddr_q;
  assign wData      = wdata_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;
  assign err_line   = eline_q;
  assign err_frame  = eframe_q;

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Directed/randomized bench for ov7670_capture_ctrl on a small
// 8x6 geometry, with a frame-level reference model.
module tb_ov7670_capture_ctrl;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int AW = 6;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cap_en, single, decim, err_clr;
  logic          href, vsync;
  logic [7:0]    cam_data;
  logic          we;
  logic [AW-1:0] wAddr;
  logic [15:0]   wData;
  logic          busy, frame_done, err_line, err_frame;
  logic [7:0]    frame_cnt;

  always #5 clk = ~clk;

  ov7670_capture_ctrl #(
    .H_RES(H), .V_RES(V), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cap_en(cap_en),
    .single(single), .decim(decim), .err_clr(err_clr),
    .href(href), .vsync(vsync), .cam_data(cam_data),
    .we(we), .wAddr(wAddr), .wData(wData), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt),
    .err_line(err_line), .err_frame(err_frame)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  wr_t         obs_q[$];
  wr_t         exp_q[$];
  logic [15:0] pix [0:15][0:15];
  int          line_len [0:15];
  int          checks = 0;
  int          passes = 0;
  int          done_cnt = 0;
  int          done_base;
  int          nobs;
  bit          exp_eline, exp_eframe;

  always @(negedge clk) begin
    if (we) obs_q.push_back({wAddr, wData});
    if (frame_done) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    assert (got === want) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  task automatic gen(input int len, input bit pattern);
    for (int l = 0; l < 16; l++) begin
      line_len[l] = len;
      for (int p = 0; p < 16; p++)
        pix[l][p] = pattern ? {8'(l), 8'(p)} : 16'($urandom);
    end
  endtask

  // Reference: every kept source pixel lands at s*H+k when inside
  // the HxV window; flags follow the kept line/pixel counts.
  task automatic model(input bit dec, input int nl);
    int s, k, nk_ln, nk_px;
    nk_ln = 0;
    for (int l = 0; l < nl; l++) begin
      if (dec && (l % 2 == 1)) continue;
      s = dec ? l / 2 : l;
      nk_ln++;
      nk_px = 0;
      for (int p = 0; p < line_len[l]; p++) begin
        if (dec && (p % 2 == 1)) continue;
        k = dec ? p / 2 : p;
        nk_px++;
        if (k < H && s < V)
          exp_q.push_back({AW'(s * H + k), pix[l][p]});
      end
      if (s < V && nk_px != H) exp_eline = 1'b1;
    end
    if (nk_ln != V) exp_eframe = 1'b1;
  endtask

  task automatic vs_pulse();
    href  = 1'b0;
    vsync = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic drive_lines(input int nl, input int raise_ln,
                             input int abort_ln, input int abort_px);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    for (int l = 0; l < nl; l++) begin
      if (l == raise_ln) cap_en = 1'b1;
      for (int p = 0; p < line_len[l]; p++) begin
        if (l == abort_ln && p == abort_px) begin
          reset_n = 1'b0;
          href    = 1'b0;
          return;
        end
        href     = 1'b1;
        cam_data = pix[l][p][15:8];
        @(negedge clk);
        cam_data = pix[l][p][7:0];
        @(negedge clk);
      end
      href     = 1'b0;
      cam_data = 8'h00;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic cmp_writes(input string tag);
    int bad;
    bad = 0;
    chk({tag, " count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) bad++;
    chk({tag, " data"}, 32'(bad), 32'd0);
  endtask

  function automatic logic [31:0] data_at(input int addr);
    for (int i = 0; i < obs_q.size(); i++)
      if (int'(obs_q[i].a) == addr) return 32'(obs_q[i].d);
    return 'x;
  endfunction

  function automatic logic [31:0] first_addr();
    if (obs_q.size() == 0) return 'x;
    return 32'(obs_q[0].a);
  endfunction

  task automatic stop_cap();
    cap_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; cap_en = 1'b0; single = 1'b0; decim = 1'b0;
    err_clr = 1'b0; href = 1'b0; vsync = 1'b0; cam_data = 8'h00;
    exp_eline = 1'b0; exp_eframe = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst we", 32'(we), 32'd0);
    chk("rst wAddr", 32'(wAddr), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst errs", 32'({err_line, err_frame, frame_done}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Continuous, two full frames.
    done_base = done_cnt;
    cap_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      gen(H, 1'b0);
      vs_pulse();
      chk("arm busy", 32'(busy), 32'd1);
      drive_lines(V, -1, -1, -1);
      model(1'b0, V);
    end
    vs_pulse();
    stop_cap();
    cmp_writes("cont");
    chk("cont done", 32'(done_cnt - done_base), 32'd2);
    chk("cont frame_cnt", 32'(frame_cnt), 32'd2);
    chk("cont err_line", 32'(err_line), 32'(exp_eline));
    chk("cont err_frame", 32'(err_frame), 32'(exp_eframe));
    chk("idle busy", 32'(busy), 32'd0);
    obs_q.delete(); exp_q.delete();

    // cap_en raised in the middle of a frame.
    gen(H, 1'b0);
    drive_lines(V, 2, -1, -1);
    chk("mid no writes", 32'(obs_q.size()), 32'd0);
    gen(H, 1'b0);
    vs_pulse();
    drive_lines(V, -1, -1, -1);
    model(1'b0, V);
    vs_pulse();
    stop_cap();
    cmp_writes("mid");
    chk("mid first addr", first_addr(), 32'd0);
    chk("mid frame_cnt", 32'(frame_cnt), 32'd3);
    obs_q.delete(); exp_q.delete();

    // Decimated 2H x 2V source with {line,pixel} pattern.
    gen(2 * H, 1'b1);
    decim = 1'b1;
    cap_en = 1'b1;
    vs_pulse();
    drive_lines(2 * V, -1, -1, -1);
    model(1'b1, 2 * V);
    vs_pulse();
    stop_cap();
    decim = 1'b0;
    cmp_writes("decim");
    chk("decim addr H+1", data_at(H + 1), 32'h0202);
    chk("decim err_frame", 32'(err_frame), 32'(exp_eframe));
    chk("decim frame_cnt", 32'(frame_cnt), 32'd4);
    obs_q.delete(); exp_q.delete();

    // Short line 2; line 3 must still start at 3*H.
    gen(H, 1'b0);
    line_len[2] = H - 2;
    cap_en = 1'b1;
    vs_pulse();
    drive_lines(V, -1, -1, -1);
    model(1'b0, V);
    vs_pulse();
    stop_cap();
    cmp_writes("short");
    chk("short line3 start", data_at(3 * H), 32'(pix[3][0]));
    chk("short err_line", 32'(err_line), 32'(exp_eline));
    chk("short err_frame", 32'(err_frame), 32'(exp_eframe));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_eline = 1'b0;
    @(negedge clk);
    chk("err_clr", 32'(err_line), 32'(exp_eline));
    obs_q.delete(); exp_q.delete();

    // Single shot with one line missing.
    gen(H, 1'b0);
    done_base = done_cnt;
    single = 1'b1;
    cap_en = 1'b1;
    vs_pulse();
    drive_lines(V - 1, -1, -1, -1);
    model(1'b0, V - 1);
    vs_pulse();
    cmp_writes("single");
    chk("single err_frame", 32'(err_frame), 32'(exp_eframe));
    chk("single busy", 32'(busy), 32'd0);
    nobs = obs_q.size();
    gen(H, 1'b0);
    drive_lines(V, -1, -1, -1);
    vs_pulse();
    chk("single no rearm", 32'(obs_q.size()), 32'(nobs));
    chk("single done", 32'(done_cnt - done_base), 32'd1);
    stop_cap();
    single = 1'b0;
    obs_q.delete(); exp_q.delete();

    // Reset mid-frame, then a clean frame.
    gen(H, 1'b0);
    done_base = done_cnt;
    cap_en = 1'b1;
    vs_pulse();
    drive_lines(V, -1, 3, 4);
    #1;
    chk("abort wAddr", 32'(wAddr), 32'd0);
    chk("abort wData", 32'(wData), 32'd0);
    chk("abort frame_cnt", 32'(frame_cnt), 32'd0);
    chk("abort flags",
        32'({we, busy, frame_done, err_line, err_frame}), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    obs_q.delete(); exp_q.delete();
    exp_eline = 1'b0; exp_eframe = 1'b0;
    gen(H, 1'b0);
    vs_pulse();
    drive_lines(V, -1, -1, -1);
    model(1'b0, V);
    vs_pulse();
    stop_cap();
    cmp_writes("post rst");
    chk("post rst first", first_addr(), 32'd0);
    chk("post rst done", 32'(done_cnt - done_base), 32'd1);
    chk("post rst frame_cnt", 32'(frame_cnt), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
